// File: rtl/dp_mem_responder_pkg.sv
// Shared types and state encodings for the datapath memory responder.
package dp_mem_responder_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned STATE_W = 3;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [STATE_W-1:0] mem_state_t;

  localparam mem_state_t S_IDLE  = 3'd0;
  localparam mem_state_t S_DACC  = 3'd1;
  localparam mem_state_t S_IACC  = 3'd2;
  localparam mem_state_t S_DRESP = 3'd3;
  localparam mem_state_t S_IRESP = 3'd4;
  localparam mem_state_t S_HALT  = 3'd5;

  // Clear the byte-offset bits so the RAM always sees a word address.
  function automatic word_t word_align(input word_t addr);
    return addr & ~word_t'(3);
  endfunction

endpackage

// File: rtl/dp_mem_responder_tmo.sv
// Wait counter for one RAM access; flags the cycle in which the wait budget runs out.
module dp_mem_responder_tmo #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire_c
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // Count access cycles without ramrdy; restart on every new access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // This stalled cycle would bring the count to TIMEOUT.
  assign expire_c = run && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dp_mem_responder.sv
// Responder side of the datapath cache interface: arbitrates instruction and
// data requests onto one single-ported RAM and returns registered hit pulses.
module dp_mem_responder
  import dp_mem_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic [31:0]      imemload,
  output logic             ihit,
  input  logic             dmemREN,
  input  logic             dmemWEN,
  input  logic [31:0]      dmemaddr,
  input  logic [31:0]      dmemstore,
  output logic [31:0]      dmemload,
  output logic             dhit,
  input  logic             halt,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic             ramrdy,
  output logic             err,
  output logic [CNT_W-1:0] icount,
  output logic [CNT_W-1:0] dcount
);

  mem_state_t       state_q, state_d;
  logic             ihit_d, dhit_d, ren_d, wen_d, err_d;
  word_t            addr_d, store_d, iload_d, dload_d;
  logic [CNT_W-1:0] icount_d, dcount_d;
  logic             tmo_clear_c, tmo_run_c, tmo_expire_c;
  logic             in_acc_c, is_d_c;

  assign in_acc_c = (state_q == S_DACC) || (state_q == S_IACC);
  assign is_d_c   = (state_q == S_DACC);

  dp_mem_responder_tmo #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk      (CLK),
    .rst_n    (nRST),
    .clear    (tmo_clear_c),
    .run      (tmo_run_c),
    .expire_c (tmo_expire_c)
  );

  // Next-state and next-output logic; every registered output has a _d here.
  always_comb begin
    state_d     = state_q;
    ihit_d      = 1'b0;
    dhit_d      = 1'b0;
    ren_d       = ramREN;
    wen_d       = ramWEN;
    addr_d      = ramaddr;
    store_d     = ramstore;
    iload_d     = imemload;
    dload_d     = dmemload;
    err_d       = err;
    icount_d    = icount;
    dcount_d    = dcount;
    tmo_clear_c = 1'b0;
    tmo_run_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (dmemREN || dmemWEN) begin
          // A simultaneous read and write request is treated as a write.
          state_d     = S_DACC;
          wen_d       = dmemWEN;
          ren_d       = !dmemWEN;
          addr_d      = word_align(dmemaddr);
          store_d     = dmemstore;
          tmo_clear_c = 1'b1;
        end else if (imemREN) begin
          state_d     = S_IACC;
          ren_d       = 1'b1;
          wen_d       = 1'b0;
          addr_d      = word_align(imemaddr);
          tmo_clear_c = 1'b1;
        end
      end

      S_DACC, S_IACC: begin
        tmo_run_c = !ramrdy;
        // ramrdy takes precedence over an expiring wait budget.
        if (ramrdy || tmo_expire_c) begin
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          state_d = is_d_c ? S_DRESP : S_IRESP;
          if (!ramrdy) begin
            err_d = 1'b1;
          end
          if (is_d_c) begin
            dhit_d   = 1'b1;
            dcount_d = dcount + CNT_W'(1);
            if (!ramrdy) begin
              dload_d = '0;
            end else if (!ramWEN) begin
              dload_d = ramload;
            end
          end else begin
            ihit_d   = 1'b1;
            icount_d = icount + CNT_W'(1);
            iload_d  = ramrdy ? ramload : '0;
          end
        end
      end

      S_DRESP, S_IRESP: begin
        state_d = S_IDLE;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      imemload <= '0;
      dmemload <= '0;
      err      <= 1'b0;
      icount   <= '0;
      dcount   <= '0;
    end else begin
      ihit     <= ihit_d;
      dhit     <= dhit_d;
      ramREN   <= ren_d;
      ramWEN   <= wen_d;
      ramaddr  <= addr_d;
      ramstore <= store_d;
      imemload <= iload_d;
      dmemload <= dload_d;
      err      <= err_d;
      icount   <= icount_d;
      dcount   <= dcount_d;
    end
  end

endmodule
